sparse_hv_bundler: RTL and testbench

//  Downstream consumer of the item-memory fetch stage: takes one level hypervector per feature and binds it to its feature ID.

---
 rtl/sparse_hdc_pkg.sv | 33 +++
 rtl/vote_counter_bank.sv | 41 ++++
 rtl/sparse_hv_bundler.sv | 158 +++++++++++++++
 tb/tb_sparse_hv_bundler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sparse_hdc_pkg.sv
// ============================================================================
// sparse_hdc_pkg : shared sparse hypervector format and bundler FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package sparse_hdc_pkg;

  localparam int HV_W       = 10;
  localparam int HV_ACT_BIT = 9;
  localparam int IDX_W      = 9;

  typedef logic [HV_W-1:0] sparse_hv_t;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  function automatic sparse_hv_t hv_pack(input logic act, input logic [IDX_W-1:0] idx);
    return {act, idx};
  endfunction

  function automatic logic hv_active(input sparse_hv_t hv);
    return hv[HV_ACT_BIT];
  endfunction

  function automatic logic [IDX_W-1:0] hv_index(input sparse_hv_t hv);
    return hv[IDX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/vote_counter_bank.sv
// ============================================================================
// vote_counter_bank : SEG_LEN saturating vote counters, one increment per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module vote_counter_bank #(
  parameter int SEG_LEN = 16,
  parameter int CNT_W   = 4,
  parameter int PTR_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  input  logic             inc_en,
  input  logic [PTR_W-1:0] inc_idx,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt
);

  logic [CNT_W-1:0] cnt_q [SEG_LEN];

  generate
    for (genvar i = 0; i < SEG_LEN; i++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q[i] <= '0;
        end else if (clr_all) begin
          cnt_q[i] <= '0;
        end else if (inc_en && (inc_idx == PTR_W'(i)) && !(&cnt_q[i])) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  endgenerate

  assign rd_cnt = cnt_q[rd_idx];

endmodule

`default_nettype wire

// File: rtl/sparse_hv_bundler.sv
// ============================================================================
// sparse_hv_bundler : binds per-feature level HVs by cyclic shift, votes, and
//                     emits the winner-take-all sparse sample HV
// Revision: 1.0
// ============================================================================
`default_nettype none

module sparse_hv_bundler
  import sparse_hdc_pkg::*;
#(
  parameter int SEG_LEN   = 16,
  parameter int NUM_FEAT  = 8,
  parameter int ID_STRIDE = 3,
  parameter int CNT_W     = $clog2(NUM_FEAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [HV_W-1:0]  level_hv_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [HV_W-1:0]  bundle_hv,
  output logic [CNT_W-1:0] bundle_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int PTR_W      = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
  localparam int FC_W       = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int STRIDE_MOD = ID_STRIDE % SEG_LEN;

  logic [1:0]       state_q, state_d;
  logic [FC_W-1:0]  feat_cnt_q, feat_cnt_d;
  logic [PTR_W-1:0] offset_q, offset_d;
  logic [PTR_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [IDX_W-1:0] best_q, best_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;

  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic [PTR_W:0]   w_pos_sum;
  logic [PTR_W-1:0] w_pos;
  logic [PTR_W:0]   w_off_sum;
  logic [PTR_W-1:0] w_off_next;
  logic             w_accept;
  logic             w_vote;
  logic             w_last;
  logic             w_handshake;
  logic             w_clr_all;
  logic [CNT_W-1:0] w_rd_cnt;

  assign w_idx      = hv_index(level_hv_in);
  assign w_in_range = ({23'b0, w_idx} < 32'(SEG_LEN));

  // Both operands are below SEG_LEN, so one conditional subtract is a full modulo.
  assign w_pos_sum  = {1'b0, w_idx[PTR_W-1:0]} + {1'b0, offset_q};
  assign w_pos      = (w_pos_sum >= (PTR_W+1)'(SEG_LEN)) ?
                      PTR_W'(w_pos_sum - (PTR_W+1)'(SEG_LEN)) : PTR_W'(w_pos_sum);
  assign w_off_sum  = {1'b0, offset_q} + (PTR_W+1)'(STRIDE_MOD);
  assign w_off_next = (w_off_sum >= (PTR_W+1)'(SEG_LEN)) ?
                      PTR_W'(w_off_sum - (PTR_W+1)'(SEG_LEN)) : PTR_W'(w_off_sum);

  assign in_ready    = (state_q == ST_ACCUM);
  assign out_valid   = (state_q == ST_OUT);
  assign busy        = (state_q != ST_ACCUM) || (feat_cnt_q != '0);
  assign w_accept    = in_valid & in_ready & ~flush;
  assign w_vote      = w_accept & hv_active(level_hv_in) & w_in_range;
  assign w_last      = (feat_cnt_q == FC_W'(NUM_FEAT - 1));
  assign w_handshake = out_valid & out_ready & ~flush;
  assign w_clr_all   = flush | w_handshake;

  assign bundle_hv  = (best_cnt_q != '0) ? hv_pack(1'b1, best_q) : '0;
  assign bundle_cnt = best_cnt_q;

  vote_counter_bank #(
    .SEG_LEN (SEG_LEN),
    .CNT_W   (CNT_W),
    .PTR_W   (PTR_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .clr_all (w_clr_all),
    .inc_en  (w_vote),
    .inc_idx (w_pos),
    .rd_idx  (scan_ptr_q),
    .rd_cnt  (w_rd_cnt)
  );

  always_comb begin
    state_d    = state_q;
    feat_cnt_d = feat_cnt_q;
    offset_d   = offset_q;
    scan_ptr_d = scan_ptr_q;
    best_d     = best_q;
    best_cnt_d = best_cnt_q;
    if (flush) begin
      state_d    = ST_ACCUM;
      feat_cnt_d = '0;
      offset_d   = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              state_d    = ST_SCAN;
              feat_cnt_d = '0;
              offset_d   = '0;
              scan_ptr_d = '0;
              best_d     = '0;
              best_cnt_d = '0;
            end else begin
              feat_cnt_d = feat_cnt_q + 1'b1;
              offset_d   = w_off_next;
            end
          end
        end
        ST_SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (w_rd_cnt > best_cnt_q) begin
            best_d     = IDX_W'(scan_ptr_q);
            best_cnt_d = w_rd_cnt;
          end
          if (scan_ptr_q == PTR_W'(SEG_LEN - 1)) begin
            state_d = ST_OUT;
          end else begin
            scan_ptr_d = scan_ptr_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (w_handshake) state_d = ST_ACCUM;
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACCUM;
      feat_cnt_q <= '0;
      offset_q   <= '0;
      scan_ptr_q <= '0;
      best_q     <= '0;
      best_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      feat_cnt_q <= feat_cnt_d;
      offset_q   <= offset_d;
      scan_ptr_q <= scan_ptr_d;
      best_q     <= best_d;
      best_cnt_q <= best_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sparse_hv_bundler.sv
// ============================================================================
// tb_sparse_hv_bundler : directed vector table plus flush/stall/reset sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sparse_hv_bundler;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [9:0] level_hv_in;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] bundle_hv;
  logic [3:0] bundle_cnt;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  sparse_hv_bundler #(
    .SEG_LEN   (16),
    .NUM_FEAT  (8),
    .ID_STRIDE (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .level_hv_in (level_hv_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bundle_hv   (bundle_hv),
    .bundle_cnt  (bundle_cnt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0][9:0] f;
    logic [9:0]      hv;
    logic [3:0]      cnt;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mkv(input logic [9:0] a0, a1, a2, a3, a4, a5, a6, a7,
                               input logic [9:0] hv, input logic [3:0] cnt);
    vec_t v;
    v.f[0] = a0; v.f[1] = a1; v.f[2] = a2; v.f[3] = a3;
    v.f[4] = a4; v.f[5] = a5; v.f[6] = a6; v.f[7] = a7;
    v.hv = hv;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Present one feature and hold it until accepted; returns the accept cycle.
  task automatic send(input logic [9:0] hv, output int t);
    int g;
    g = 0;
    level_hv_in = hv;
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("in_ready_timeout", 0, 1);
    t = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_sample(input vec_t v, output int t_last);
    for (int i = 0; i < 8; i++) send(v.f[i], t_last);
  endtask

  task automatic wait_out(output int t);
    int g;
    g = 0;
    while (!out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("out_valid_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, int'(out_valid), 0);
    chk({nm, "_busy_idle"}, int'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int t_last, t_out;
    send_sample(v, t_last);
    wait_out(t_out);
    chk({nm, "_latency"}, t_out - t_last, 17);
    chk({nm, "_hv"}, int'(bundle_hv), int'(v.hv));
    chk({nm, "_cnt"}, int'(bundle_cnt), int'(v.cnt));
    chk({nm, "_busy_out"}, int'(busy), 1);
    handshake(nm);
  endtask

  initial begin
    int t_last, t_out;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; level_hv_in = '0;
    vecs[0] = mkv(10'h205, 10'h202, 10'h20F, 10'h20C, 10'h209, 10'h206, 10'h203, 10'h200, 10'h205, 4'd8);
    vecs[1] = mkv(10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 4'd1);
    vecs[2] = mkv(10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 4'd0);
    vecs[3] = mkv(10'h21F, 10'h21F, 10'h21F, 10'h21F, 10'h21F, 10'h21F, 10'h21F, 10'h21F, 10'h000, 4'd0);
    vecs[4] = mkv(10'h207, 10'h204, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h207, 4'd2);
    vecs[5] = mkv(10'h20A, 10'h207, 10'h202, 10'h20F, 10'h214, 10'h005, 10'h000, 10'h000, 10'h208, 4'd2);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_hv", int'(bundle_hv), 0);
    chk("rst_cnt", int'(bundle_cnt), 0);
    chk("rst_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Downstream stall: outputs held, new input ignored, no stale votes afterwards.
    send_sample(vecs[0], t_last);
    wait_out(t_out);
    level_hv_in = 10'h203;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_hv", int'(bundle_hv), 10'h205);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stall_cnt", int'(bundle_cnt), 8);
    handshake("stall");
    run_vec(vecs[1], "after_stall");

    // Flush after three accepts, colliding with a fourth offered feature.
    for (int i = 0; i < 3; i++) send(10'h207, t_last);
    chk("pre_flush_busy", int'(busy), 1);
    level_hv_in = 10'h207;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", int'(busy), 0);
    run_vec(vecs[0], "after_flush");

    // Reset pulse during SCAN.
    send_sample(vecs[0], t_last);
    repeat (5) @(negedge clk);
    chk("mid_scan_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("scan_rst_valid", int'(out_valid), 0);
    chk("scan_rst_busy", int'(busy), 0);
    chk("scan_rst_hv", int'(bundle_hv), 0);
    chk("scan_rst_cnt", int'(bundle_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("scan_rst_in_ready", int'(in_ready), 1);
    run_vec(vecs[5], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
